fu_wb_arbiter: RTL

- Result-collection end of the functional-unit output interface.
- Accepts fu_output_t completions (pc, id, prd, rdval) from NB_FU functional units (ALU, MUL, LSU, ...) into per-unit skid FIFOs.
- Arbitrates them round-robin onto a single writeback port toward the register file and commit logic, with back-pressure in both directions.

---
 rtl/fu_wb_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/fu_wb_arbiter.sv
// Functional-unit writeback arbiter: per-source skid FIFOs merged round-robin onto one writeback port.
// Build option WB_BYPASS_EN: when idle, an incoming result reaches writeback in the same cycle.
package fu_wb_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [7:0]  id;
        logic [5:0]  prd;
        logic [31:0] rdval;
    } fu_output_t;
endpackage

// Handshake: a transfer happens on a port in any cycle where its valid and ready are both 1;
// a producer holding valid with ready low keeps valid and payload stable until the transfer.
module fu_wb_arbiter
    import fu_wb_pkg::*;
#(
    parameter int NB_FU = 3,
    parameter int DEPTH = 2,
    parameter int IDXW  = $clog2(NB_FU)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NB_FU-1:0]       fu_valid_i,
    input  fu_output_t [NB_FU-1:0] fu_result_i,
    output logic [NB_FU-1:0]       fu_ready_o,
    output logic                   wb_valid_o,
    output fu_output_t             wb_result_o,
    output logic [IDXW-1:0]        wb_src_o,
    input  logic                   wb_ready_i
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);
    localparam logic [IDXW:0]   NB_FU_C  = (IDXW+1)'(NB_FU);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NB_FU - 1);

    fu_output_t       mem    [NB_FU][DEPTH];
    logic [PW-1:0]    wr_ptr [NB_FU];
    logic [PW-1:0]    rd_ptr [NB_FU];
    logic [CW-1:0]    count  [NB_FU];
    logic [NB_FU-1:0] not_empty;
    logic [NB_FU-1:0] full;
    logic [NB_FU-1:0] push;
    logic [NB_FU-1:0] pop;
    logic [IDXW-1:0]  rr_ptr;
    logic [IDXW-1:0]  grant;
    logic [IDXW-1:0]  lock_idx;
    logic             lock;
    logic             wb_fire;
    fu_output_t       head;

    // First set bit of vec, searching upward from ptr and wrapping at NB_FU.
    function automatic logic [IDXW-1:0] rr_pick(input logic [NB_FU-1:0] vec,
                                                 input logic [IDXW-1:0]  ptr);
        logic [IDXW-1:0] pick;
        logic [IDXW:0]   s;
        logic            found;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NB_FU; k++) begin
            s = {1'b0, ptr} + (IDXW+1)'(k);
            if (s >= NB_FU_C) s = s - NB_FU_C;
            if (!found && vec[s[IDXW-1:0]]) begin
                pick  = s[IDXW-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        for (int i = 0; i < NB_FU; i++) begin
            not_empty[i] = (count[i] != '0);
            full[i]      = (count[i] == DEPTH_C);
        end
    end

    assign fu_ready_o = ~full;

`ifdef WB_BYPASS_EN
    logic bypass;
    assign bypass = ~|not_empty && !lock;
`endif

    always_comb begin
        grant      = '0;
        wb_valid_o = 1'b0;
        head       = '0;
`ifdef WB_BYPASS_EN
        if (bypass) begin
            grant      = rr_pick(fu_valid_i, rr_ptr);
            wb_valid_o = |fu_valid_i;
            head       = fu_result_i[grant];
        end else
`endif
        begin
            grant      = lock ? lock_idx : rr_pick(not_empty, rr_ptr);
            wb_valid_o = |not_empty;
            head       = mem[grant][rd_ptr[grant]];
        end
    end

    assign wb_fire     = wb_valid_o && wb_ready_i;
    assign wb_result_o = wb_valid_o ? head : '0;
    assign wb_src_o    = wb_valid_o ? grant : '0;

    always_comb begin
        for (int i = 0; i < NB_FU; i++) begin
            push[i] = fu_valid_i[i] && !full[i];
            pop[i]  = wb_fire && (grant == IDXW'(i));
`ifdef WB_BYPASS_EN
            // A bypassed entry never sits in its FIFO unless writeback stalls it.
            if (bypass && (grant == IDXW'(i))) begin
                pop[i] = 1'b0;
                if (wb_ready_i) push[i] = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB_FU; i++) begin
            if (push[i]) mem[i][wr_ptr[i]] <= fu_result_i[i];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NB_FU; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr_ptr   <= '0;
            lock     <= 1'b0;
            lock_idx <= '0;
        end else begin
            for (int i = 0; i < NB_FU; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + CW'(1);
                    2'b01:   count[i] <= count[i] - CW'(1);
                    default: ;
                endcase
            end
            if (wb_fire) rr_ptr <= (grant == LAST_IDX) ? '0 : grant + IDXW'(1);
            // Holding the grant keeps the presented entry stable while writeback stalls.
            if (wb_valid_o && !wb_ready_i) begin
                lock     <= 1'b1;
                lock_idx <= grant;
            end else if (wb_fire) begin
                lock <= 1'b0;
            end
        end
    end

endmodule
